// File: rtl/l2_mesi_cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// l2_cache_pkg : shared types for the L2 MESI tag/state controller
// Rev 1.0
// ============================================================================
package l2_cache_pkg;

  typedef enum logic [2:0] {
    CMD_L1_READ   = 3'd0,
    CMD_L1_WRITE  = 3'd1,
    CMD_L1_IFETCH = 3'd2,
    CMD_SNP_INV   = 3'd3,
    CMD_SNP_READ  = 3'd4,
    CMD_SNP_WRITE = 3'd5,
    CMD_SNP_RFO   = 3'd6,
    CMD_CLEAR     = 3'd7
  } cmd_t;

  typedef enum logic [1:0] {MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3} mesi_t;

  typedef enum logic [1:0] {BUS_NONE = 2'd0, BUS_READ = 2'd1, BUS_RFO = 2'd2, BUS_INV = 2'd3} bus_op_t;

  typedef enum logic [1:0] {SNP_NOHIT = 2'd0, SNP_HIT = 2'd1, SNP_HITM = 2'd2, SNP_RSVD = 2'd3} snoop_rsp_t;

  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_LOOKUP = 2'd2, ST_UPDATE = 2'd3} state_t;

endpackage
`default_nettype wire

// File: rtl/l2_mesi_cache_ctrl_if.sv
`default_nettype none
// ============================================================================
// l2_mesi_cache_ctrl_if : command/response bus of the L2 tag/state controller
// Rev 1.0
// ============================================================================
interface l2_mesi_cache_ctrl_if
  import l2_cache_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int CNT_W     = 32
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  cmd_t                 cmd;
  logic [ADDR_BITS-1:0] addr;
  logic                 other_shared;
  logic                 rsp_valid;
  logic                 hit;
  logic                 miss;
  bus_op_t              bus_op;
  logic                 writeback;
  snoop_rsp_t           snoop_rsp;
  logic [CNT_W-1:0]     read_cnt;
  logic [CNT_W-1:0]     write_cnt;
  logic [CNT_W-1:0]     hit_cnt;
  logic [CNT_W-1:0]     miss_cnt;

  modport master (
    output cmd_valid, cmd, addr, other_shared,
    input  cmd_ready, rsp_valid, hit, miss, bus_op, writeback, snoop_rsp,
    input  read_cnt, write_cnt, hit_cnt, miss_cnt
  );

  modport slave (
    input  cmd_valid, cmd, addr, other_shared,
    output cmd_ready, rsp_valid, hit, miss, bus_op, writeback, snoop_rsp,
    output read_cnt, write_cnt, hit_cnt, miss_cnt
  );
endinterface
`default_nettype wire

// File: rtl/l2_mesi_cache_ctrl_lru_update.sv
`default_nettype none
// ============================================================================
// l2_lru_update : true-LRU age update for one set plus replacement victim pick
// Rev 1.0
// ============================================================================
module l2_lru_update #(
  parameter  int WAYS  = 8,
  localparam int LRU_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][LRU_W-1:0] ages_in,
  input  logic [WAYS-1:0]            valid,
  input  logic [LRU_W-1:0]           way,
  output logic [WAYS-1:0][LRU_W-1:0] ages_out,
  output logic [LRU_W-1:0]           victim
);

  always_comb begin
    ages_out = ages_in;
    for (int w = 0; w < WAYS; w++) begin
      if (ages_in[w] < ages_in[way]) ages_out[w] = ages_in[w] + 1'b1;
    end
    ages_out[way] = '0;
  end

  // An empty way always wins over evicting the oldest valid line.
  always_comb begin
    logic found;
    found  = 1'b0;
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid[w] && !found) begin
        victim = LRU_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (ages_in[w] == LRU_W'(WAYS - 1)) victim = LRU_W'(w);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_mesi_cache_ctrl.sv
`default_nettype none
// ============================================================================
// l2_mesi_cache_ctrl : set-associative L2 tag/MESI/LRU controller with stats
// Rev 1.0
// ============================================================================
module l2_mesi_cache_ctrl
  import l2_cache_pkg::*;
#(
  parameter int ADDR_BITS  = 32,
  parameter int BYTE_SEL   = 6,
  parameter int INDEX_BITS = 14,
  parameter int WAYS       = 8,
  parameter int CNT_W      = 32
) (
  input logic                 clock,
  input logic                 reset,
  l2_mesi_cache_ctrl_if.slave bus
);

  localparam int SETS     = 1 << INDEX_BITS;
  localparam int LRU_W    = $clog2(WAYS);
  localparam int LINE_W   = ADDR_BITS - BYTE_SEL;
  localparam int TAG_BITS = LINE_W - INDEX_BITS;

  logic [TAG_BITS-1:0]           tag_mem  [SETS][WAYS];
  mesi_t                         mesi_mem [SETS][WAYS];
  logic [WAYS-1:0][LRU_W-1:0]    age_mem  [SETS];

  state_t                        state, state_nxt;
  logic [INDEX_BITS-1:0]         set_ptr;
  logic                          clear_pending;
  cmd_t                          cmd_q;
  logic [LINE_W-1:0]             line_q;

  logic                          wr_en, wr_lru;
  logic [LRU_W-1:0]              wr_way;
  mesi_t                         wr_mesi;
  logic [WAYS-1:0][LRU_W-1:0]    wr_ages;

  logic [INDEX_BITS-1:0]         idx;
  logic [TAG_BITS-1:0]           tag_in;
  logic [WAYS-1:0]               valid_vec, match_vec;
  logic                          hit_any;
  logic [LRU_W-1:0]              hit_way, victim_way, touch_way;
  logic [WAYS-1:0][LRU_W-1:0]    ages_next;
  mesi_t                         cur_mesi, vic_mesi, lk_mesi;
  logic                          lk_hit, lk_miss, lk_wb, lk_wr_en, lk_lru;
  bus_op_t                       lk_bus;
  snoop_rsp_t                    lk_snp;
  logic                          accept;
  logic                          unused_byte_sel;

  assign unused_byte_sel = ^bus.addr[BYTE_SEL-1:0];
  assign bus.cmd_ready   = (state == ST_IDLE) && !reset;
  assign accept          = (state == ST_IDLE) && bus.cmd_valid;
  assign idx             = line_q[INDEX_BITS-1:0];
  assign tag_in          = line_q[INDEX_BITS +: TAG_BITS];

  always_ff @(posedge clock) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:   if (&set_ptr) state_nxt = ST_IDLE;
      ST_IDLE:   if (bus.cmd_valid) state_nxt = (bus.cmd == CMD_CLEAR) ? ST_INIT : ST_LOOKUP;
      ST_LOOKUP: state_nxt = ST_UPDATE;
      ST_UPDATE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      valid_vec[w] = (mesi_mem[idx][w] != MESI_I);
      match_vec[w] = valid_vec[w] && (tag_mem[idx][w] == tag_in);
      if (match_vec[w]) hit_way = LRU_W'(w);
    end
  end

  assign hit_any   = |match_vec;
  assign touch_way = hit_any ? hit_way : victim_way;
  assign cur_mesi  = mesi_mem[idx][hit_way];
  assign vic_mesi  = mesi_mem[idx][victim_way];

  l2_lru_update #(.WAYS(WAYS)) u_lru (
    .ages_in  (age_mem[idx]),
    .valid    (valid_vec),
    .way      (touch_way),
    .ages_out (ages_next),
    .victim   (victim_way)
  );

  // Lookup outcome: coherence transition, bus request and snoop answer.
  always_comb begin
    lk_hit   = 1'b0;
    lk_miss  = 1'b0;
    lk_bus   = BUS_NONE;
    lk_wb    = 1'b0;
    lk_snp   = SNP_NOHIT;
    lk_wr_en = 1'b0;
    lk_lru   = 1'b0;
    lk_mesi  = cur_mesi;
    case (cmd_q)
      CMD_L1_READ, CMD_L1_IFETCH: begin
        lk_wr_en = 1'b1;
        lk_lru   = 1'b1;
        if (hit_any) begin
          lk_hit = 1'b1;
        end else begin
          lk_miss = 1'b1;
          lk_bus  = BUS_READ;
          lk_mesi = bus.other_shared ? MESI_S : MESI_E;
          lk_wb   = (vic_mesi == MESI_M);
        end
      end
      CMD_L1_WRITE: begin
        lk_wr_en = 1'b1;
        lk_lru   = 1'b1;
        lk_mesi  = MESI_M;
        if (hit_any) begin
          lk_hit = 1'b1;
          lk_bus = (cur_mesi == MESI_S) ? BUS_INV : BUS_NONE;
        end else begin
          lk_miss = 1'b1;
          lk_bus  = BUS_RFO;
          lk_wb   = (vic_mesi == MESI_M);
        end
      end
      CMD_SNP_READ: if (hit_any) begin
        lk_wr_en = 1'b1;
        lk_mesi  = MESI_S;
        lk_snp   = (cur_mesi == MESI_M) ? SNP_HITM : SNP_HIT;
        lk_wb    = (cur_mesi == MESI_M);
      end
      CMD_SNP_RFO: if (hit_any) begin
        lk_wr_en = 1'b1;
        lk_mesi  = MESI_I;
        lk_snp   = (cur_mesi == MESI_M) ? SNP_HITM : SNP_HIT;
        lk_wb    = (cur_mesi == MESI_M);
      end
      CMD_SNP_INV: if (hit_any && cur_mesi == MESI_S) begin
        lk_wr_en = 1'b1;
        lk_mesi  = MESI_I;
        lk_snp   = SNP_HIT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      set_ptr       <= '0;
      clear_pending <= 1'b0;
      cmd_q         <= CMD_L1_READ;
      line_q        <= '0;
      wr_en         <= 1'b0;
      wr_lru        <= 1'b0;
      wr_way        <= '0;
      wr_mesi       <= MESI_I;
      wr_ages       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.hit       <= 1'b0;
      bus.miss      <= 1'b0;
      bus.bus_op    <= BUS_NONE;
      bus.writeback <= 1'b0;
      bus.snoop_rsp <= SNP_NOHIT;
      bus.read_cnt  <= '0;
      bus.write_cnt <= '0;
      bus.hit_cnt   <= '0;
      bus.miss_cnt  <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          set_ptr <= set_ptr + 1'b1;
          if (&set_ptr) begin
            bus.rsp_valid <= clear_pending;
            bus.hit       <= 1'b0;
            bus.miss      <= 1'b0;
            bus.bus_op    <= BUS_NONE;
            bus.writeback <= 1'b0;
            bus.snoop_rsp <= SNP_NOHIT;
            clear_pending <= 1'b0;
          end
        end
        ST_IDLE: if (accept) begin
          cmd_q  <= bus.cmd;
          line_q <= bus.addr[ADDR_BITS-1:BYTE_SEL];
          if (bus.cmd == CMD_CLEAR) begin
            clear_pending <= 1'b1;
            set_ptr       <= '0;
            bus.read_cnt  <= '0;
            bus.write_cnt <= '0;
            bus.hit_cnt   <= '0;
            bus.miss_cnt  <= '0;
          end
        end
        ST_LOOKUP: begin
          bus.rsp_valid <= 1'b1;
          bus.hit       <= lk_hit;
          bus.miss      <= lk_miss;
          bus.bus_op    <= lk_bus;
          bus.writeback <= lk_wb;
          bus.snoop_rsp <= lk_snp;
          wr_en         <= lk_wr_en;
          wr_lru        <= lk_lru;
          wr_way        <= touch_way;
          wr_mesi       <= lk_mesi;
          wr_ages       <= ages_next;
          if (cmd_q == CMD_L1_READ || cmd_q == CMD_L1_IFETCH) bus.read_cnt <= bus.read_cnt + CNT_W'(1);
          if (cmd_q == CMD_L1_WRITE) bus.write_cnt <= bus.write_cnt + CNT_W'(1);
          if (lk_hit)  bus.hit_cnt  <= bus.hit_cnt + CNT_W'(1);
          if (lk_miss) bus.miss_cnt <= bus.miss_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Arrays commit on the edge leaving UPDATE, so a reset during UPDATE leaves them untouched.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == ST_INIT) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_mem[set_ptr][w]  <= '0;
          mesi_mem[set_ptr][w] <= MESI_I;
          age_mem[set_ptr][w]  <= LRU_W'(w);
        end
      end else if (state == ST_UPDATE && wr_en) begin
        tag_mem[idx][wr_way]  <= tag_in;
        mesi_mem[idx][wr_way] <= wr_mesi;
        if (wr_lru) age_mem[idx] <= wr_ages;
      end
    end
  end

  a_single_match : assert property (@(posedge clock) disable iff (reset)
    (state == ST_LOOKUP) |-> $onehot0(match_vec));

endmodule
`default_nettype wire

// File: tb/tb_l2_mesi_cache_ctrl.sv
`default_nettype none
// ============================================================================
// tb_l2_mesi_cache_ctrl : randomized self-checking bench with a recency-stamp reference model
// Rev 1.0
// ============================================================================
module tb_l2_mesi_cache_ctrl;
  import l2_cache_pkg::*;

  localparam int IB   = 2;
  localparam int NW   = 4;
  localparam int SETS = 4;
  localparam int MI = 0, MS = 1, ME = 2, MM = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  l2_mesi_cache_ctrl_if #(.ADDR_BITS(32), .CNT_W(32)) bus ();

  l2_mesi_cache_ctrl #(
    .ADDR_BITS(32), .BYTE_SEL(6), .INDEX_BITS(IB), .WAYS(NW), .CNT_W(32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  int          m_mesi  [SETS][NW];
  logic [23:0] m_tag   [SETS][NW];
  longint      m_stamp [SETS][NW];
  longint      m_time;
  int unsigned m_rd, m_wr, m_hit, m_miss;

  logic last_hit, last_miss, last_wb;
  int   last_bus, last_snp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_init();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < NW; w++) begin
        m_mesi[s][w]  = MI;
        m_tag[s][w]   = '0;
        m_stamp[s][w] = -w;
      end
    m_time = 0;
    m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0;
  endtask

  function automatic int pick_victim(input int s);
    int v;
    for (int w = 0; w < NW; w++) if (m_mesi[s][w] == MI) return w;
    v = 0;
    for (int w = 1; w < NW; w++) if (m_stamp[s][w] < m_stamp[s][v]) v = w;
    return v;
  endfunction

  task automatic model_step(input int c, input logic [31:0] a, input logic sh,
                            output int eh, output int em, output int eb, output int ew, output int es);
    int s, hw, v;
    logic [23:0] t;
    s = int'(a[7:6]);
    t = a[31:8];
    hw = -1;
    eh = 0; em = 0; eb = 0; ew = 0; es = 0;
    for (int w = 0; w < NW; w++) if (m_mesi[s][w] != MI && m_tag[s][w] == t) hw = w;
    if (c <= 2) begin
      if (c == 1) m_wr++; else m_rd++;
      if (hw >= 0) begin
        eh = 1; m_hit++;
        if (c == 1) begin
          eb = (m_mesi[s][hw] == MS) ? 3 : 0;
          m_mesi[s][hw] = MM;
        end
        v = hw;
      end else begin
        em = 1; m_miss++;
        v  = pick_victim(s);
        ew = (m_mesi[s][v] == MM) ? 1 : 0;
        m_tag[s][v]  = t;
        m_mesi[s][v] = (c == 1) ? MM : (sh ? MS : ME);
        eb = (c == 1) ? 2 : 1;
      end
      m_time++;
      m_stamp[s][v] = m_time;
    end else if (hw >= 0) begin
      case (c)
        3: if (m_mesi[s][hw] == MS) begin es = 1; m_mesi[s][hw] = MI; end
        4: begin
          es = (m_mesi[s][hw] == MM) ? 2 : 1;
          ew = (m_mesi[s][hw] == MM) ? 1 : 0;
          m_mesi[s][hw] = MS;
        end
        6: begin
          es = (m_mesi[s][hw] == MM) ? 2 : 1;
          ew = (m_mesi[s][hw] == MM) ? 1 : 0;
          m_mesi[s][hw] = MI;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_counters(input string pfx);
    check({pfx, "_read_cnt"},  bus.read_cnt,  m_rd);
    check({pfx, "_write_cnt"}, bus.write_cnt, m_wr);
    check({pfx, "_hit_cnt"},   bus.hit_cnt,   m_hit);
    check({pfx, "_miss_cnt"},  bus.miss_cnt,  m_miss);
  endtask

  task automatic do_reset();
    int n;
    @(negedge clock);
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_init();
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_bus_op",    bus.bus_op,    0);
    check("rst_snoop_rsp", bus.snoop_rsp, 0);
    check_counters("rst");
    n = 0;
    while (!bus.cmd_ready && n < 50) begin n++; @(negedge clock); end
    check("rst_init_cycles", n, SETS);
  endtask

  task automatic send(input int c, input logic [31:0] a, input logic sh);
    int n, lat, eh, em, eb, ew, es;
    logic rdy_low;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin @(negedge clock); n++; end
    if (!bus.cmd_ready) begin
      check("ready_timeout", bus.cmd_ready, 1);
      return;
    end
    bus.cmd          = cmd_t'(c[2:0]);
    bus.addr         = a;
    bus.other_shared = sh;
    bus.cmd_valid    = 1'b1;
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    lat = 1;
    rdy_low = 1'b1;
    while (!bus.rsp_valid && lat < 40) begin
      if (bus.cmd_ready) rdy_low = 1'b0;
      @(negedge clock);
      lat++;
    end
    check("latency", lat, (c == 7) ? SETS + 1 : 2);
    if (!bus.rsp_valid) return;
    if (c == 7) begin
      check("clear_busy", rdy_low, 1);
      model_init();
      eh = 0; em = 0; eb = 0; ew = 0; es = 0;
    end else begin
      model_step(c, a, sh, eh, em, eb, ew, es);
    end
    last_hit  = bus.hit;
    last_miss = bus.miss;
    last_wb   = bus.writeback;
    last_bus  = int'(bus.bus_op);
    last_snp  = int'(bus.snoop_rsp);
    check("hit",       bus.hit,       eh);
    check("miss",      bus.miss,      em);
    check("bus_op",    bus.bus_op,    eb);
    check("writeback", bus.writeback, ew);
    check("snoop_rsp", bus.snoop_rsp, es);
    check_counters("rsp");
  endtask

  function automatic logic [31:0] mk_addr(input int tag, input int set);
    return (32'(tag) << 8) | (32'(set) << 6);
  endfunction

  task automatic reset_in_lookup();
    int n;
    logic seen;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin @(negedge clock); n++; end
    bus.cmd          = CMD_L1_WRITE;
    bus.addr         = mk_addr(9, 3);
    bus.other_shared = 1'b0;
    bus.cmd_valid    = 1'b1;
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("rstlk_rsp_now", bus.rsp_valid, 0);
    reset = 1'b0;
    model_init();
    n = 0;
    seen = 1'b0;
    while (!bus.cmd_ready && n < 50) begin
      if (bus.rsp_valid) seen = 1'b1;
      @(negedge clock);
      n++;
    end
    check("rstlk_no_rsp", seen, 0);
    check("rstlk_init_cycles", n, SETS);
    check_counters("rstlk");
  endtask

  initial begin
    bus.cmd_valid    = 1'b0;
    bus.cmd          = CMD_L1_READ;
    bus.addr         = '0;
    bus.other_shared = 1'b0;
    model_init();

    do_reset();

    send(0, 32'h0000_0100, 1'b0);
    check("dir_rd1_miss", last_miss, 1);
    check("dir_rd1_bus",  last_bus,  1);
    send(0, 32'h0000_0100, 1'b0);
    check("dir_rd2_hit", last_hit, 1);
    check("dir_rd2_bus", last_bus, 0);
    check("dir_read_cnt", bus.read_cnt, 2);
    check("dir_hit_cnt",  bus.hit_cnt,  1);
    check("dir_miss_cnt", bus.miss_cnt, 1);

    send(4, 32'h0000_0100, 1'b0);
    check("dir_snprd_hit", last_snp, 1);
    send(1, 32'h0000_0100, 1'b0);
    check("dir_wr_inval", last_bus, 3);
    send(4, 32'h0000_0100, 1'b0);
    check("dir_snprd_hitm", last_snp, 2);
    send(1, 32'h0000_0100, 1'b0);

    for (int t = 1; t <= 5; t++) send(0, mk_addr(t, 1), 1'b0);
    check("dir_evict_clean_wb", last_wb, 0);
    send(0, mk_addr(1, 1), 1'b0);
    check("dir_evicted_miss", last_miss, 1);

    for (int t = 1; t <= 4; t++) send(1, mk_addr(t, 2), 1'b0);
    send(0, mk_addr(5, 2), 1'b1);
    check("dir_evict_dirty_wb", last_wb, 1);

    send(6, 32'h0000_0100, 1'b0);
    check("dir_snprfo_hitm", last_snp, 2);
    check("dir_snprfo_wb",   last_wb,  1);
    send(0, 32'h0000_0100, 1'b0);
    check("dir_after_rfo_miss", last_miss, 1);

    send(7, 32'h0, 1'b0);
    send(0, mk_addr(5, 2), 1'b0);
    check("dir_after_clear_miss", last_miss, 1);

    reset_in_lookup();

    for (int i = 0; i < 400; i++) begin
      int c;
      c = ($urandom_range(0, 63) == 0) ? 7 : int'($urandom_range(0, 6));
      send(c, mk_addr(int'($urandom_range(1, 6)), int'($urandom_range(0, 3))) | 32'($urandom_range(0, 63)),
           1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
`default_nettype wire
